// File: rtl/score_tracker.sv
// Score, coin and row tracker for one game; follows the game FSM state and
// raises a one-cycle idle_timeout pulse when the player stops advancing.
`timescale 1ns/1ps
module score_tracker #(
   parameter logic [9:0]  SCORE_MAX   = 10'd999,
   parameter logic [9:0]  COIN_MAX    = 10'd999,
   parameter logic [9:0]  BACK_LIMIT  = 10'd3,
   parameter logic [27:0] IDLE_CYCLES = 28'd200_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] game_state,
   input  logic       move_fwd,
   input  logic       move_back,
   input  logic       coin_hit,
   output logic [9:0] score,
   output logic [9:0] coin,
   output logic [9:0] row,
   output logic       idle_timeout
);

   localparam int unsigned W  = 10;
   localparam int unsigned CW = 28;

   localparam logic [2:0] GS_MAIN = 3'd0;
   localparam logic [2:0] GS_PLAY = 3'd1;
   localparam logic [2:0] GS_DEAD = 3'd2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_FROZEN = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic            r_fwd_d;
   logic            r_back_d;
   logic            r_coin_d;
   logic [W-1:0]    r_score;
   logic [W-1:0]    r_coin;
   logic [W-1:0]    r_row;
   logic [CW-1:0]   r_idle_cnt;
   logic            r_timeout;

   logic [W-1:0]    w_score_nxt;
   logic [W-1:0]    w_coin_nxt;
   logic [W-1:0]    w_row_nxt;
   logic [CW-1:0]   w_cnt_nxt;
   logic            w_timeout_nxt;

   logic            w_run;
   logic            w_enter_run;
   logic            w_fwd_ev;
   logic            w_back_ev;
   logic            w_coin_ev;
   logic            w_fwd_only;
   logic            w_back_only;
   logic            w_back_ok;
   logic [W-1:0]    w_row_inc;
   logic [W-1:0]    w_coin_inc;
   logic [W:0]      w_row_lim;

   assign w_run       = (r_state == ST_RUN);
   assign w_enter_run = (w_state_nxt == ST_RUN) && !w_run;

   // Events are only honoured while already running; edge flops run always.
   assign w_fwd_ev    = move_fwd  & ~r_fwd_d  & w_run;
   assign w_back_ev   = move_back & ~r_back_d & w_run;
   assign w_coin_ev   = coin_hit  & ~r_coin_d & w_run;
   assign w_fwd_only  = w_fwd_ev  & ~w_back_ev;
   assign w_back_only = w_back_ev & ~w_fwd_ev;

   assign w_row_inc  = (r_row  >= SCORE_MAX) ? SCORE_MAX : r_row + W'(1);
   assign w_coin_inc = (r_coin >= COIN_MAX)  ? COIN_MAX  : r_coin + W'(1);

   // Retreat limit evaluated one bit wider so row+BACK_LIMIT cannot wrap.
   assign w_row_lim  = {1'b0, r_row} + {1'b0, BACK_LIMIT};
   assign w_back_ok  = (r_row != '0) && (w_row_lim > {1'b0, r_score});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (game_state == GS_PLAY) w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (game_state == GS_DEAD)      w_state_nxt = ST_FROZEN;
            else if (game_state == GS_MAIN) w_state_nxt = ST_IDLE;
         end
         ST_FROZEN: begin
            if (game_state == GS_PLAY)      w_state_nxt = ST_RUN;
            else if (game_state == GS_MAIN) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Datapath next-state: clear on game entry, update on events while running.
   always_comb begin
      w_score_nxt   = r_score;
      w_coin_nxt    = r_coin;
      w_row_nxt     = r_row;
      w_cnt_nxt     = '0;
      w_timeout_nxt = 1'b0;
      if (w_enter_run) begin
         w_score_nxt = '0;
         w_coin_nxt  = '0;
         w_row_nxt   = '0;
      end else if (w_run) begin
         if (w_fwd_only) begin
            w_row_nxt = w_row_inc;
            if (w_row_inc > r_score) w_score_nxt = w_row_inc;
         end else begin
            if (w_back_only && w_back_ok) w_row_nxt = r_row - W'(1);
            if (r_idle_cnt >= IDLE_CYCLES - CW'(1)) begin
               w_timeout_nxt = 1'b1;
            end else begin
               w_cnt_nxt = r_idle_cnt + CW'(1);
            end
         end
         if (w_coin_ev) w_coin_nxt = w_coin_inc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fwd_d    <= 1'b0;
         r_back_d   <= 1'b0;
         r_coin_d   <= 1'b0;
         r_score    <= '0;
         r_coin     <= '0;
         r_row      <= '0;
         r_idle_cnt <= '0;
         r_timeout  <= 1'b0;
      end else begin
         r_fwd_d    <= move_fwd;
         r_back_d   <= move_back;
         r_coin_d   <= coin_hit;
         r_score    <= w_score_nxt;
         r_coin     <= w_coin_nxt;
         r_row      <= w_row_nxt;
         r_idle_cnt <= w_cnt_nxt;
         r_timeout  <= w_timeout_nxt;
      end
   end

   assign score        = r_score;
   assign coin         = r_coin;
   assign row          = r_row;
   assign idle_timeout = r_timeout;

endmodule

// File: tb/tb_score_tracker.sv
// Self-checking bench for score_tracker: vector table through a scoreboard
// queue, then hand sequences for hold, timeout, saturation and async reset.
`timescale 1ns/1ps
module tb_score_tracker;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] game_state;
   logic       move_fwd;
   logic       move_back;
   logic       coin_hit;
   logic [9:0] score;
   logic [9:0] coin;
   logic [9:0] row;
   logic       idle_timeout;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [2:0] gs;
      logic       f;
      logic       b;
      logic       c;
      logic [9:0] s;
      logic [9:0] k;
      logic [9:0] r;
      logic       to;
   } vec_t;

   localparam int NV = 46;
   vec_t vecs [NV];
   vec_t sb [$];

   always #5 clk = ~clk;

   score_tracker #(.IDLE_CYCLES(28'd16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .game_state   (game_state),
      .move_fwd     (move_fwd),
      .move_back    (move_back),
      .coin_hit     (coin_hit),
      .score        (score),
      .coin         (coin),
      .row          (row),
      .idle_timeout (idle_timeout)
   );

   function automatic vec_t mk(input int gs, input bit f, input bit b, input bit c,
                               input int s, input int k, input int r);
      vec_t v;
      v.gs = 3'(gs); v.f = f; v.b = b; v.c = c;
      v.s = 10'(s); v.k = 10'(k); v.r = 10'(r); v.to = 1'b0;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input vec_t v, input int idx);
      vec_t e;
      game_state = v.gs; move_fwd = v.f; move_back = v.b; coin_hit = v.c;
      sb.push_back(v);
      tick();
      e = sb.pop_front();
      chk($sformatf("vec%0d score", idx), 32'(score), 32'(e.s));
      chk($sformatf("vec%0d coin", idx),  32'(coin),  32'(e.k));
      chk($sformatf("vec%0d row", idx),   32'(row),   32'(e.r));
      chk($sformatf("vec%0d timeout", idx), 32'(idle_timeout), 32'(e.to));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // gs f b c -> score coin row
      vecs[0]  = mk(0,0,0,0, 0,0,0);
      vecs[1]  = mk(1,0,0,0, 0,0,0);
      vecs[2]  = mk(1,1,0,0, 1,0,1);
      vecs[3]  = mk(1,0,0,0, 1,0,1);
      vecs[4]  = mk(1,1,0,0, 2,0,2);
      vecs[5]  = mk(1,0,0,0, 2,0,2);
      vecs[6]  = mk(1,1,0,0, 3,0,3);
      vecs[7]  = mk(1,0,0,0, 3,0,3);
      vecs[8]  = mk(1,1,0,0, 4,0,4);
      vecs[9]  = mk(1,0,0,0, 4,0,4);
      vecs[10] = mk(1,1,0,0, 5,0,5);
      vecs[11] = mk(1,0,0,0, 5,0,5);
      vecs[12] = mk(1,0,1,0, 5,0,4);
      vecs[13] = mk(1,0,0,0, 5,0,4);
      vecs[14] = mk(1,0,1,0, 5,0,3);
      vecs[15] = mk(1,0,0,0, 5,0,3);
      vecs[16] = mk(1,0,0,1, 5,1,3);
      vecs[17] = mk(1,0,0,0, 5,1,3);
      vecs[18] = mk(1,0,0,1, 5,2,3);
      vecs[19] = mk(1,0,0,0, 5,2,3);
      vecs[20] = mk(1,0,0,1, 5,3,3);
      vecs[21] = mk(1,0,0,0, 5,3,3);
      vecs[22] = mk(1,0,1,0, 5,3,2);
      vecs[23] = mk(1,0,0,0, 5,3,2);
      vecs[24] = mk(1,1,0,1, 5,4,3);
      vecs[25] = mk(1,0,0,0, 5,4,3);
      vecs[26] = mk(1,0,1,0, 5,4,2);
      vecs[27] = mk(1,0,0,0, 5,4,2);
      vecs[28] = mk(1,0,1,0, 5,4,2);
      vecs[29] = mk(1,0,0,0, 5,4,2);
      vecs[30] = mk(1,1,1,0, 5,4,2);
      vecs[31] = mk(1,0,0,0, 5,4,2);
      vecs[32] = mk(2,0,0,0, 5,4,2);
      vecs[33] = mk(2,1,0,0, 5,4,2);
      vecs[34] = mk(2,0,0,0, 5,4,2);
      vecs[35] = mk(2,0,0,1, 5,4,2);
      vecs[36] = mk(0,0,0,0, 5,4,2);
      vecs[37] = mk(0,1,0,0, 5,4,2);
      vecs[38] = mk(1,0,0,0, 0,0,0);
      vecs[39] = mk(1,0,1,0, 0,0,0);
      vecs[40] = mk(1,0,0,0, 0,0,0);
      vecs[41] = mk(5,1,0,0, 1,0,1);
      vecs[42] = mk(5,0,0,0, 1,0,1);
      vecs[43] = mk(2,1,0,0, 2,0,2);
      vecs[44] = mk(1,0,0,0, 0,0,0);
      vecs[45] = mk(0,0,0,0, 0,0,0);

      rst_n = 1'b0; game_state = 3'd0;
      move_fwd = 1'b0; move_back = 1'b0; coin_hit = 1'b0;
      #12;
      chk("reset score", 32'(score), 32'd0);
      chk("reset coin", 32'(coin), 32'd0);
      chk("reset row", 32'(row), 32'd0);
      chk("reset timeout", 32'(idle_timeout), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) apply(vecs[i], i);

      // Level held high for 100 cycles counts once.
      game_state = 3'd1; tick();
      move_fwd = 1'b1;
      repeat (100) tick();
      chk("hold row", 32'(row), 32'd1);
      chk("hold score", 32'(score), 32'd1);

      // Timeout pulse every 16 cycles after the last forward move.
      move_fwd = 1'b0; tick();
      move_fwd = 1'b1; tick();
      chk("fwd row", 32'(row), 32'd2);
      chk("fwd timeout", 32'(idle_timeout), 32'd0);
      move_fwd = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         tick();
         chk($sformatf("idle k%0d", k), 32'(idle_timeout), 32'((k % 16) == 0));
      end
      repeat (7) tick();
      chk("pre-expiry timeout", 32'(idle_timeout), 32'd0);
      move_fwd = 1'b1; tick();
      chk("fwd beats expiry", 32'(idle_timeout), 32'd0);
      chk("fwd beats expiry row", 32'(row), 32'd3);
      move_fwd = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         tick();
         chk($sformatf("restart k%0d", k), 32'(idle_timeout), 32'(k == 16));
      end

      // Coin and row saturation.
      repeat (1000) begin
         coin_hit = 1'b1; tick();
         coin_hit = 1'b0; tick();
      end
      chk("coin sat", 32'(coin), 32'd999);
      repeat (1000) begin
         move_fwd = 1'b1; tick();
         move_fwd = 1'b0; tick();
      end
      chk("row sat", 32'(row), 32'd999);
      chk("score sat", 32'(score), 32'd999);
      move_back = 1'b1; tick();
      move_back = 1'b0; tick();
      chk("back from max", 32'(row), 32'd998);
      chk("score after back", 32'(score), 32'd999);

      // Asynchronous reset mid-game, checked before the next clock edge.
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("async score", 32'(score), 32'd0);
      chk("async coin", 32'(coin), 32'd0);
      chk("async row", 32'(row), 32'd0);
      chk("async timeout", 32'(idle_timeout), 32'd0);
      game_state = 3'd0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      move_fwd = 1'b1; tick();
      chk("post-reset idle row", 32'(row), 32'd0);
      move_fwd = 1'b0; tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
